// File: rtl/rpll_cfg_pkg.sv
// Shared types and the rPLL divider mode table for the reconfiguration controller.
// Codes are in rPLL dynamic encoding: IDSEL/FBDSEL = ~(*DIV_SEL), ODSEL as the ODIV code.
package rpll_cfg_pkg;

  typedef logic [1:0] mode_t;

  typedef enum logic [2:0] {
    ASSERT_RST,
    WAIT_LOCK,
    STABLE,
    READY,
    FAULT
  } state_e;

  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
  } div_codes_t;

  // 0: 124.875 MHz (IDIV_SEL 7, FBDIV_SEL 36, ODIV 8)
  localparam div_codes_t MODE0_CODES = '{idsel: 6'd56, fbdsel: 6'd27, odsel: 6'b111100};
  // 1: 74.25 MHz (IDIV_SEL 3, FBDIV_SEL 10, ODIV 8)
  localparam div_codes_t MODE1_CODES = '{idsel: 6'd60, fbdsel: 6'd53, odsel: 6'b111100};
  // 2: 148.5 MHz (IDIV_SEL 1, FBDIV_SEL 10, ODIV 4)
  localparam div_codes_t MODE2_CODES = '{idsel: 6'd62, fbdsel: 6'd53, odsel: 6'b111110};
  // 3: 25.2 MHz (IDIV_SEL 14, FBDIV_SEL 13, ODIV 32)
  localparam div_codes_t MODE3_CODES = '{idsel: 6'd49, fbdsel: 6'd50, odsel: 6'b110000};

  function automatic div_codes_t mode_codes(input mode_t m);
    case (m)
      2'd0:    return MODE0_CODES;
      2'd1:    return MODE1_CODES;
      2'd2:    return MODE2_CODES;
      default: return MODE3_CODES;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared by synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rpll_reconfig_ctrl.sv
// rPLL dynamic-divider sequencer: applies a mode's divider codes, pulses PLL reset,
// waits for a stable synchronized lock, and retries or faults on lock failure.
module rpll_reconfig_ctrl
  import rpll_cfg_pkg::*;
#(
  parameter int RST_CYCLES    = 32,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int DEFAULT_MODE  = 0
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       mode_req,
  input  logic [1:0] mode_sel,
  output logic       mode_ack,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       clk_ready,
  output logic [1:0] cur_mode,
  output logic       pll_fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_A   = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int CNT_MAX = (CNT_A > STABLE_CYCLES) ? CNT_A : STABLE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam mode_t DEF_MODE = mode_t'(DEFAULT_MODE);

  state_e     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] retry_nx;
  mode_t      mode_nx;
  logic [7:0] loss_nx;
  logic       accept;
  logic       lock_s;
  div_codes_t codes_q;

  sync_2ff u_lock_sync (
    .clk   (clkin),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    retry_nx = retry_cnt;
    mode_nx  = cur_mode;
    loss_nx  = lock_loss_cnt;
    accept   = 1'b0;
    case (state)
      ASSERT_RST: begin
        if (cnt == CW'(RST_CYCLES - 1)) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end
      end
      WAIT_LOCK: begin
        // a lock arriving on the timeout cycle still counts as a lock
        if (lock_s) begin
          state_nx = STABLE;
          cnt_nx   = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          cnt_nx   = '0;
          retry_nx = retry_cnt + 2'd1;
          state_nx = (retry_nx < 2'(MAX_RETRY)) ? ASSERT_RST : FAULT;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
          state_nx = READY;
          cnt_nx   = '0;
        end
      end
      READY: begin
        cnt_nx = '0;
        if (!lock_s) begin
          if (lock_loss_cnt != 8'hFF) loss_nx = lock_loss_cnt + 8'd1;
          retry_nx = '0;
          state_nx = ASSERT_RST;
        end
      end
      FAULT: cnt_nx = '0;
      default: begin
        state_nx = ASSERT_RST;
        cnt_nx   = '0;
      end
    endcase
    // a mode request overrides any lock-loss relock but keeps the loss count
    if (mode_req && (state == READY || state == FAULT)) begin
      accept   = 1'b1;
      mode_nx  = mode_sel;
      retry_nx = '0;
      state_nx = ASSERT_RST;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state         <= ASSERT_RST;
      cnt           <= '0;
      retry_cnt     <= '0;
      cur_mode      <= DEF_MODE;
      lock_loss_cnt <= '0;
      mode_ack      <= 1'b0;
      pll_reset     <= 1'b1;
      clk_ready     <= 1'b0;
      pll_fault     <= 1'b0;
      codes_q       <= mode_codes(DEF_MODE);
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      retry_cnt     <= retry_nx;
      cur_mode      <= mode_nx;
      lock_loss_cnt <= loss_nx;
      mode_ack      <= accept;
      pll_reset     <= (state_nx == ASSERT_RST) || (state_nx == FAULT);
      clk_ready     <= (state == READY) && (state_nx == READY);
      pll_fault     <= (state_nx == FAULT);
      codes_q       <= mode_codes(mode_nx);
    end
  end

  assign pll_idsel  = codes_q.idsel;
  assign pll_fbdsel = codes_q.fbdsel;
  assign pll_odsel  = codes_q.odsel;

endmodule

// File: doc/rpll_reconfig_ctrl.md
Name: rpll_reconfig_ctrl

Overview:
Sequencer for the Gowin rPLL instance running in dynamic-divider mode on the 27 MHz board clock. It selects one of a small table of output-clock modes (pixel/TX clock rates), drives the PLL reset and the IDSEL/FBDSEL/ODSEL divider codes, and waits for a stable lock. It then raises clk_ready to gate downstream video logic, recovers automatically from lock loss, and flags a fault after repeated lock failures.

Parameters:
RST_CYCLES, 32, clkin cycles pll_reset is held high per attempt (min 2)
LOCK_TIMEOUT, 27000, clkin cycles allowed from reset release to first synchronized lock (1 ms)
STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before clk_ready
MAX_RETRY, 3, failed lock attempts before entering FAULT (1..3)
DEFAULT_MODE, 0, mode index applied after reset

Ports:
clkin  in  1  27 MHz reference clock, also the controller clock
reset  in  1  synchronous, active-high reset
mode_req  in  1  level request for a mode change; requester holds it until mode_ack
mode_sel  in  2  requested mode index, sampled when mode_ack is driven
mode_ack  out  1  one-cycle acceptance pulse
pll_lock  in  1  rPLL LOCK, asynchronous to clkin
pll_reset  out  1  to rPLL RESET
pll_idsel  out  6  to rPLL IDSEL
pll_fbdsel  out  6  to rPLL FBDSEL
pll_odsel  out  6  to rPLL ODSEL
clk_ready  out  1  PLL output valid and stable
cur_mode  out  2  mode currently applied
pll_fault  out  1  lock failed MAX_RETRY times
retry_cnt  out  2  failed attempts in the current sequence
lock_loss_cnt  out  8  lock drops while READY, saturates at 255

Behaviour:
- Clock and reset: one clock (clkin); reset is synchronous and active-high.
- Lock synchronizer: pll_lock passes through a 2-flop synchronizer to give lock_s. All lock decisions use lock_s, so lock has 2 cycles of latency.
- Reset values: pll_reset=1, clk_ready=0, mode_ack=0, pll_fault=0, retry_cnt=0, lock_loss_cnt=0, cur_mode=DEFAULT_MODE, sel outputs = table codes for DEFAULT_MODE. State = ASSERT_RST with its counter cleared.
- Divider codes: sel outputs are registered copies of the mode table codes. The codes are already in rPLL dynamic encoding and are driven unmodified. They change only in the cycle a sequence starts, so they are stable at least RST_CYCLES before pll_reset falls.
- ASSERT_RST: pll_reset=1 for exactly RST_CYCLES cycles, then pll_reset=0 and go to WAIT_LOCK with the timeout counter cleared.
- WAIT_LOCK:
  - lock_s=1 -> STABLE.
  - Counter reaches LOCK_TIMEOUT -> retry_cnt+1. If the new value is below MAX_RETRY -> ASSERT_RST; otherwise -> FAULT.
- STABLE:
  - Counts consecutive lock_s=1 cycles; reaching STABLE_CYCLES -> READY, clk_ready=1 from the next cycle.
  - lock_s=0 -> WAIT_LOCK with the timeout counter restarted; retry_cnt is unchanged.
- READY:
  - clk_ready=1.
  - lock_s=0 -> clk_ready=0 in the next cycle, lock_loss_cnt+1 (saturating), retry_cnt=0, -> ASSERT_RST with the same mode.
- FAULT: pll_fault=1, pll_reset=1, clk_ready=0. The block stays here until mode_req or reset.
- Mode request:
  - Accepted only in READY or FAULT.
  - On acceptance: mode_ack=1 for one cycle, cur_mode and sel outputs take mode_sel, retry_cnt=0, pll_fault=0, clk_ready=0, -> ASSERT_RST.
  - In any other state mode_req is not acknowledged and stays pending.
  - Re-requesting the current mode is legal and performs a full relock.
- Simultaneous events:
  - mode_req and lock loss in the same READY cycle: the request wins (ack, new mode), and lock_loss_cnt still increments.
  - Lock timeout and lock_s rising in the same cycle: lock wins.
- Reset mid-operation: returns immediately to the reset values and restarts the sequence with DEFAULT_MODE. No pending request survives.
- Counter widths: counters are sized with $clog2 of their parameter; no wrap is possible before the terminal compare.

Decomposition:
- Package rpll_cfg_pkg holds:
  - mode index type (2 bits) and state enum {ASSERT_RST, WAIT_LOCK, STABLE, READY, FAULT};
  - mode table constants with encoded IDSEL/FBDSEL/ODSEL for four modes: 0 = 124.875 MHz (IDIV 7, FBDIV 36, ODIV 8), 1 = 74.25 MHz, 2 = 148.5 MHz, 3 = 25.2 MHz.
- One sub-module: sync_2ff (1-bit two-flop synchronizer, reset to 0).

Test Plan:
Bench uses RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=3.
1. Nominal bring-up: release reset, model raises pll_lock 10 cycles after pll_reset falls -> pll_reset high exactly 4 cycles; clk_ready rises 2+8+1 cycles after lock; sel = mode-0 codes; retry_cnt=0.
2. Mode change: in READY, mode_req=1, mode_sel=2 -> mode_ack pulses once, clk_ready=0 next cycle, sel = mode-2 codes before pll_reset falls, cur_mode=2, ready again after relock.
3. Lock never asserts -> three 20-cycle timeouts; retry_cnt goes 1, 2, 3; pll_fault=1 and pll_reset held high. Then mode_req with mode_sel=1 -> fault clears, sequence restarts.
4. Lock glitch: lock drops for 3 cycles mid-STABLE -> back to WAIT_LOCK, retry_cnt unchanged, stable count restarts. Lock drop in READY -> lock_loss_cnt=1 and a relock with the same mode.
5. Collision and pending: mode_req coincides with lock loss in READY -> ack, new mode applied, lock_loss_cnt increments. mode_req raised in WAIT_LOCK -> no ack until READY.
6. Reset in STABLE while mode 3 is active -> cur_mode=0, mode-0 codes, pll_reset=1, counters cleared on the next edge.
